// File: rtl/smem_pkg.sv
// Shared definitions for the shared-memory round-robin arbiter.
// No logic; state encoding, core count and lane-packing helper.
// Backpressure: n/a.
package smem_pkg;

    localparam int N_CORES = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    // Bit offset of a core's lane inside a packed per-core bus.
    function automatic int lane_lsb(input int core, input int width);
        return core * width;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way rotating-priority picker; search starts just after last_grant.
// Latency: zero cycles (pure combinational).
// Backpressure: none; valid_o low when no request is present.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] last_grant_i,
    output logic [1:0] grant_o,
    output logic       valid_o
);

    logic [1:0] idx;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant_o = 2'd0;
        valid_o = 1'b0;
        idx     = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_grant_i + 2'(k);
            if (req_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port among four cores.
// Latency: grant at cycle 0, strobes cycles 1..MEM_LAT, ack at MEM_LAT+1.
// Backpressure: requesting cores see stall until their own ack pulse.
module shared_mem_rr_arbiter
    import smem_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CORES-1:0]   sbit,
    input  logic [N_CORES-1:0]   rd,
    input  logic [N_CORES-1:0]   wr,
    input  logic [N_CORES*AW-1:0] addr_in,
    input  logic [N_CORES*DW-1:0] wdata_in,
    output logic [N_CORES-1:0]   stall,
    output logic [N_CORES-1:0]   ack,
    output logic [DW-1:0]        rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 shared_access,
    output logic                 err
);

    typedef struct packed {
        logic          wr;
        logic [1:0]    core;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } xact_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    last_grant_q, last_grant_d;
    xact_t         xact_q, xact_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [N_CORES-1:0] req;
    logic [1:0]         pick_idx;
    logic               pick_vld;

    assign req = sbit & (rd | wr);

    rr_pick4 u_pick (
        .req_i        (req[3:0]),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_idx),
        .valid_o      (pick_vld)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        xact_d       = xact_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    // Write wins when a core raises both strobes; the conflict is flagged.
                    xact_d.core  = pick_idx;
                    xact_d.wr    = wr[pick_idx];
                    xact_d.addr  = addr_in[lane_lsb(int'(pick_idx), AW) +: AW];
                    xact_d.wdata = wdata_in[lane_lsb(int'(pick_idx), DW) +: DW];
                    if (rd[pick_idx] && wr[pick_idx]) begin
                        err_d = 1'b1;
                    end
                    last_grant_d = pick_idx;
                    cnt_d        = CNT_INIT;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!xact_q.wr) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 2'd3;
            xact_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            xact_q       <= xact_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == S_RESP) begin
            ack[xact_q.core] = 1'b1;
        end
    end

    assign stall         = req & ~ack;
    assign shared_access = (state_q == S_ACCESS);
    assign mem_read      = shared_access & ~xact_q.wr;
    assign mem_write     = shared_access & xact_q.wr;
    assign mem_addr      = xact_q.addr;
    assign mem_wdata     = xact_q.wdata;
    assign rdata         = rdata_q;
    assign err           = err_q;

endmodule
